// File: rtl/sram_access_ctrl_if.sv
// Bus between the LC-3 control path, the sequencer and the external SRAM.
// The control side drives requests, write data, switches and the SRAM
// data-in pins; the sequencer drives everything else.
interface sram_access_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              Req_RD;
  logic              Req_WR;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] Wr_Data;
  logic [DATA_W-1:0] Switches;
  logic [DATA_W-1:0] Rd_Data;
  logic              Done;
  logic              Busy;
  logic [DATA_W-1:0] Hex_Data;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [DATA_W-1:0] SRAM_DQ_in;
  logic [DATA_W-1:0] SRAM_DQ_out;
  logic              SRAM_DQ_oe;
  logic              CE_n;
  logic              OE_n;
  logic              WE_n;
  logic              UB_n;
  logic              LB_n;

  modport master (
    output Req_RD, Req_WR, ADDR, Wr_Data, Switches, SRAM_DQ_in,
    input  Rd_Data, Done, Busy, Hex_Data, SRAM_ADDR, SRAM_DQ_out,
    input  SRAM_DQ_oe, CE_n, OE_n, WE_n, UB_n, LB_n
  );

  modport slave (
    input  Req_RD, Req_WR, ADDR, Wr_Data, Switches, SRAM_DQ_in,
    output Rd_Data, Done, Busy, Hex_Data, SRAM_ADDR, SRAM_DQ_out,
    output SRAM_DQ_oe, CE_n, OE_n, WE_n, UB_n, LB_n
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// SRAM access sequencer for the LC-3 datapath.
// Turns single-cycle read/write requests into timed asynchronous SRAM bus
// cycles with WAIT_RD / WAIT_WR wait states and pulses Done on completion.
// All strobes are registered decodes of the FSM state, so the bus view lags
// the state register by one clock.
// Optional feature macro: MMIO_SWITCH_EN maps address 0xFFFF to the board
// switches (read) and the hex display register (write).
module sram_access_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int WAIT_RD = 1,
  parameter int WAIT_WR = 1
) (
  input logic                Clk,
  input logic                Reset,
  sram_access_ctrl_if.slave  bus
);

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_CAP   = 3'd2,
    WR_SETUP = 3'd3,
    WR_PULSE = 3'd4,
    WR_HOLD  = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              accept_s, accept_wr_s;
  logic              mmio_s;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              ce_n_r, oe_n_r, we_n_r, dq_oe_r, done_r, busy_r, cap_r;
  logic              ce_n_s, oe_n_s, we_n_s, dq_oe_s, done_s, busy_s, cap_s;

  // Next-state and wait-counter logic; requests only count in IDLE, write wins
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    accept_s    = 1'b0;
    accept_wr_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.Req_WR) begin
          state_s     = WR_SETUP;
          accept_s    = 1'b1;
          accept_wr_s = 1'b1;
        end else if (bus.Req_RD) begin
          state_s  = RD_WAIT;
          accept_s = 1'b1;
          cnt_s    = CNT_W'(WAIT_RD - 1);
        end else begin
          state_s = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = RD_CAP;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      RD_CAP:   state_s = DONE;
      WR_SETUP: begin
        state_s = WR_PULSE;
        cnt_s   = CNT_W'(WAIT_WR - 1);
      end
      WR_PULSE: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = WR_HOLD;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      WR_HOLD:  state_s = DONE;
      DONE:     state_s = IDLE;
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State register and wait-state down-counter
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Strobe decode from the current state; MMIO accesses keep the SRAM idle
  always_comb begin
    ce_n_s  = 1'b1;
    oe_n_s  = 1'b1;
    we_n_s  = 1'b1;
    dq_oe_s = 1'b0;
    done_s  = 1'b0;
    busy_s  = 1'b1;
    cap_s   = 1'b0;
    case (state_r)
      IDLE:     busy_s = 1'b0;
      RD_WAIT: begin
        ce_n_s = mmio_s;
        oe_n_s = mmio_s;
      end
      RD_CAP: begin
        ce_n_s = mmio_s;
        oe_n_s = mmio_s;
        cap_s  = 1'b1;
      end
      WR_SETUP, WR_HOLD: begin
        ce_n_s  = mmio_s;
        dq_oe_s = ~mmio_s;
      end
      WR_PULSE: begin
        ce_n_s  = mmio_s;
        dq_oe_s = ~mmio_s;
        we_n_s  = mmio_s;
      end
      DONE:     done_s = 1'b1;
      default:  busy_s = 1'b0;
    endcase
  end

  // Registered bus strobes; reset forces them inactive without a clock
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ce_n_r  <= 1'b1;
      oe_n_r  <= 1'b1;
      we_n_r  <= 1'b1;
      dq_oe_r <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      cap_r   <= 1'b0;
    end else begin
      ce_n_r  <= ce_n_s;
      oe_n_r  <= oe_n_s;
      we_n_r  <= we_n_s;
      dq_oe_r <= dq_oe_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
      cap_r   <= cap_s;
    end
  end

  // Latch address on any accepted request and write data on writes
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
    end else begin
      if (accept_s) begin
        addr_r <= bus.ADDR;
      end
      if (accept_wr_s) begin
        wdata_r <= bus.Wr_Data;
      end
    end
  end

  // Capture read data at the end of the bus cycle where RD_CAP is driven
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (cap_r) begin
      rd_data_r <= mmio_s ? bus.Switches : bus.SRAM_DQ_in;
    end
  end

`ifdef MMIO_SWITCH_EN
  localparam logic [ADDR_W-1:0] MMIO_ADDR = ADDR_W'(32'h0000_FFFF);

  logic              mmio_r;
  logic              hold_r;
  logic [DATA_W-1:0] hex_r;

  // Tag the access as MMIO when it is accepted
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mmio_r <= 1'b0;
    end else if (accept_s) begin
      mmio_r <= (bus.ADDR == MMIO_ADDR);
    end
  end

  // Hex display register loads at the end of the bus-level WR_HOLD cycle
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hold_r <= 1'b0;
      hex_r  <= {DATA_W{1'b0}};
    end else begin
      hold_r <= (state_r == WR_HOLD);
      if (hold_r && mmio_r) begin
        hex_r <= wdata_r;
      end
    end
  end

  assign mmio_s       = mmio_r;
  assign bus.Hex_Data = hex_r;
`else
  assign mmio_s       = 1'b0;
  assign bus.Hex_Data = {DATA_W{1'b0}};
`endif

  assign bus.SRAM_ADDR   = addr_r;
  assign bus.SRAM_DQ_out = wdata_r;
  assign bus.SRAM_DQ_oe  = dq_oe_r;
  assign bus.CE_n        = ce_n_r;
  assign bus.OE_n        = oe_n_r;
  assign bus.WE_n        = we_n_r;
  assign bus.UB_n        = 1'b0;
  assign bus.LB_n        = 1'b0;
  assign bus.Done        = done_r;
  assign bus.Busy        = busy_r;
  assign bus.Rd_Data     = rd_data_r;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: a vector table of single accesses
// plus hand sequences for reset state, requests while busy and reset
// asserted in the middle of a write. A small SRAM model latches data on the
// rising edge of WE_n and drives read data while CE_n and OE_n are low.
module tb_sram_access_ctrl;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  sram_access_ctrl_if #(.ADDR_W(20), .DATA_W(16)) bus ();

  sram_access_ctrl #(.ADDR_W(20), .DATA_W(16), .WAIT_RD(1), .WAIT_WR(1)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // SRAM model
  logic [15:0] mem [256];
  logic [15:0] last_wr_data;
  int          wr_count;

  assign bus.SRAM_DQ_in = (bus.CE_n == 1'b0 && bus.OE_n == 1'b0) ?
                          mem[bus.SRAM_ADDR[7:0]] : 16'hDEAD;

  always @(posedge bus.WE_n) begin
    if (bus.CE_n === 1'b0 && bus.SRAM_DQ_oe === 1'b1) begin
      mem[bus.SRAM_ADDR[7:0]] = bus.SRAM_DQ_out;
      last_wr_data = bus.SRAM_DQ_out;
      wr_count = wr_count + 1;
    end
  end

  typedef struct {
    logic        wr;
    logic        rd;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] sw;
    int          exp_done_k;
    logic [15:0] exp_rd;
    int          exp_we;
    int          exp_oe;
    int          exp_ce;
    int          exp_dq;
    int          exp_writes;
    logic [15:0] exp_hex;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one access, observe 16 cycles after the sampling edge, compare.
  // If rd_pulse is set, Req_RD is held high through edges 2..4 (while busy).
  task automatic run_vec(input vec_t v, input string tag, input bit rd_pulse);
    int first_done, done_cnt, we_low, oe_low, ce_low, dq_hi, clash, wr0;
    logic [15:0] rd_at_done;
    first_done = -1; done_cnt = 0; we_low = 0; oe_low = 0; ce_low = 0;
    dq_hi = 0; clash = 0; rd_at_done = 16'h0000;
    wr0 = wr_count;
    @(posedge Clk); #1;
    bus.Req_WR = v.wr; bus.Req_RD = v.rd; bus.ADDR = v.addr;
    bus.Wr_Data = v.wdata; bus.Switches = v.sw;
    @(posedge Clk); #1;                       // edge 0 sampled the request
    bus.Req_WR = 1'b0; bus.Req_RD = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge Clk);
      if (bus.Done) begin
        if (first_done < 0) begin
          first_done = k;
          rd_at_done = bus.Rd_Data;
        end
        done_cnt++;
      end
      if (!bus.WE_n) we_low++;
      if (!bus.OE_n) oe_low++;
      if (!bus.CE_n) ce_low++;
      if (bus.SRAM_DQ_oe) dq_hi++;
      if ((!bus.OE_n && !bus.WE_n) || (!bus.OE_n && bus.SRAM_DQ_oe)) clash++;
      if (rd_pulse && k == 1) begin
        bus.Req_RD = 1'b1; bus.ADDR = 20'h00012;
      end
      if (rd_pulse && k == 4) bus.Req_RD = 1'b0;
    end
    check({tag, " done_cycle"}, first_done, v.exp_done_k);
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " rd_at_done"}, {16'h0, rd_at_done}, {16'h0, v.exp_rd});
    check({tag, " rd_after"}, {16'h0, bus.Rd_Data}, {16'h0, v.exp_rd});
    check({tag, " we_low_cycles"}, we_low, v.exp_we);
    check({tag, " oe_low_cycles"}, oe_low, v.exp_oe);
    check({tag, " ce_low_cycles"}, ce_low, v.exp_ce);
    check({tag, " dq_oe_cycles"}, dq_hi, v.exp_dq);
    check({tag, " strobe_clash"}, clash, 0);
    check({tag, " sram_writes"}, wr_count - wr0, v.exp_writes);
    if (v.exp_writes > 0) check({tag, " sram_wr_data"}, {16'h0, last_wr_data}, {16'h0, v.wdata});
    check({tag, " hex"}, {16'h0, bus.Hex_Data}, {16'h0, v.exp_hex});
    check({tag, " busy_idle"}, bus.Busy, 1'b0);
  endtask

  initial begin
    vec_t v;
    checks = 0; errors = 0; wr_count = 0; last_wr_data = 16'h0000;
    bus.Req_RD = 1'b0; bus.Req_WR = 1'b0; bus.ADDR = 20'h0;
    bus.Wr_Data = 16'h0; bus.Switches = 16'h00A5;

    //          wr    rd    addr       wdata     sw        dk rd        we oe ce dq wr hex
    vecs[0] = '{1'b1, 1'b0, 20'h00012, 16'hBEEF, 16'h00A5, 4, 16'h0000, 1, 0, 3, 3, 1, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 20'h00012, 16'h0000, 16'h00A5, 3, 16'hBEEF, 0, 2, 2, 0, 0, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 20'h00034, 16'h1234, 16'h00A5, 4, 16'hBEEF, 1, 0, 3, 3, 1, 16'h0000};
    vecs[3] = '{1'b0, 1'b1, 20'h00034, 16'h0000, 16'h00A5, 3, 16'h1234, 0, 2, 2, 0, 0, 16'h0000};
`ifdef MMIO_SWITCH_EN
    vecs[4] = '{1'b1, 1'b0, 20'h0FFFF, 16'h0042, 16'h00A5, 4, 16'h1234, 0, 0, 0, 0, 0, 16'h0042};
    vecs[5] = '{1'b0, 1'b1, 20'h0FFFF, 16'h0000, 16'h00A5, 3, 16'h00A5, 0, 0, 0, 0, 0, 16'h0042};
`else
    vecs[4] = '{1'b1, 1'b0, 20'h0FFFF, 16'h0042, 16'h00A5, 4, 16'h1234, 1, 0, 3, 3, 1, 16'h0000};
    vecs[5] = '{1'b0, 1'b1, 20'h0FFFF, 16'h0000, 16'h00A5, 3, 16'h0042, 0, 2, 2, 0, 0, 16'h0000};
`endif

    // Reset state
    Reset = 1'b1;
    #2 Reset = 1'b0;
    #1;
    check("rst CE_n", bus.CE_n, 1'b1);
    check("rst OE_n", bus.OE_n, 1'b1);
    check("rst WE_n", bus.WE_n, 1'b1);
    check("rst DQ_oe", bus.SRAM_DQ_oe, 1'b0);
    check("rst Done", bus.Done, 1'b0);
    check("rst Busy", bus.Busy, 1'b0);
    check("rst Rd_Data", bus.Rd_Data, 16'h0000);
    check("rst SRAM_ADDR", bus.SRAM_ADDR, 20'h00000);
    check("rst Hex", bus.Hex_Data, 16'h0000);
    check("rst UB_LB", {bus.UB_n, bus.LB_n}, 2'b00);
    @(posedge Clk); @(posedge Clk); @(negedge Clk);
    Reset = 1'b1;

    // Table-driven accesses
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);
    end

    // Req_RD held while busy with a write: ignored, one Done, Rd_Data kept
    v = '{1'b1, 1'b0, 20'h00040, 16'h5A5A, 16'h00A5, 4, vecs[5].exp_rd, 1, 0, 3, 3, 1, vecs[5].exp_hex};
    run_vec(v, "busy_ignore", 1'b1);

    // Reset asserted during WR_PULSE
    @(posedge Clk); #1;
    bus.Req_WR = 1'b1; bus.ADDR = 20'h00012; bus.Wr_Data = 16'h0BAD;
    @(posedge Clk); #1;
    bus.Req_WR = 1'b0;
    @(negedge Clk); @(negedge Clk); @(negedge Clk);   // bus cycle 2: WE_n pulse
    check("midrst pre WE_n", bus.WE_n, 1'b0);
    #1 Reset = 1'b0;
    #1;
    check("midrst WE_n", bus.WE_n, 1'b1);
    check("midrst DQ_oe", bus.SRAM_DQ_oe, 1'b0);
    check("midrst CE_n", bus.CE_n, 1'b1);
    check("midrst Busy", bus.Busy, 1'b0);
    check("midrst Rd_Data", bus.Rd_Data, 16'h0000);
    @(posedge Clk); @(posedge Clk); @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk); @(negedge Clk);
    check("midrst idle Busy", bus.Busy, 1'b0);
    check("midrst idle Done", bus.Done, 1'b0);

    // Normal operation resumes from IDLE
    v = '{1'b0, 1'b1, 20'h00040, 16'h0000, 16'h00A5, 3, 16'h5A5A, 0, 2, 2, 0, 0, 16'h0000};
    run_vec(v, "post_reset_read", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
